nios_system_switch_debouncer: RTL and testbench

Synchronizes and debounces the raw DE2 slide-switch inputs before they reach the switches PIO `in_port`. Each bit passes through a 2-flop synchronizer, then must hold a new level for a programmable number of sample ticks before the debounced output follows it. A per-bit one-cycle `changed` pulse reports each accepted transition. The PIO's edge capture therefore sees exactly one clean edge per physical switch flip.

---
 rtl/nios_system_switch_debouncer.sv | 150 +++++++++++++++
 tb/tb_nios_system_switch_debouncer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_switch_debouncer.sv
// -----------------------------------------------------------------------------
// nios_system_switch_debouncer
//
// Purpose:
//   Cleans up the raw DE2 slide-switch pins before they reach the switches PIO
//   in_port. Every bit is first brought into the clk domain by a 2-flop
//   synchronizer. It must then hold a new level for STABLE_TICKS consecutive
//   sample ticks before the debounced output follows it. One shared,
//   free-running prescaler produces a sample tick every TICK_DIV clocks.
//   Each accepted transition raises a one-cycle pulse on the matching bit of
//   `changed`, so the PIO edge capture sees exactly one edge per switch flip.
//
// Parameters:
//   WIDTH        number of switch bits
//   TICK_DIV     clock cycles per sample tick (>= 1)
//   STABLE_TICKS consecutive mismatching ticks needed to accept a level (>= 1)
//   RESET_VALUE  reset value of the synchronizer stages and debounced state
//
// Ports:
//   clk          in   1      system clock; all logic uses the rising edge
//   reset_n      in   1      asynchronous active-low reset, synchronous release
//                            expected from the system reset controller
//   raw_sw       in   WIDTH  asynchronous switch pins
//   debounced    out  WIDTH  registered stable level (drives PIO in_port)
//   changed      out  WIDTH  registered one-cycle pulse per accepted transition
//   any_changed  out  1      registered OR of `changed`, aligned with it
//
// There is no valid/ready handshake. The outputs are level/pulse signals
// that are sampled every cycle by the consumer.
// -----------------------------------------------------------------------------
module nios_system_switch_debouncer #(
    parameter int               WIDTH        = 18,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_sw,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] changed,
    output logic             any_changed
);

    // -------------------------------------------------------------------------
    // Derived widths and terminal values
    // -------------------------------------------------------------------------
    // Both counters need at least one bit, even when they only ever hold 0
    // (TICK_DIV == 1 or STABLE_TICKS == 1).
    localparam int PS_W  = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
    localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [PS_W-1:0]  PS_ONE   = PS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Synchronizer
    // -------------------------------------------------------------------------
    // s1 may go metastable; only s2 is used downstream.
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RESET_VALUE;
            s2 <= RESET_VALUE;
        end else begin
            s1 <= raw_sw;
            s2 <= s1;
        end
    end

    // -------------------------------------------------------------------------
    // Shared prescaler
    // -------------------------------------------------------------------------
    // Counts 0..TICK_DIV-1 and wraps. tick is high during the terminal count,
    // so the first tick after reset release falls in cycle TICK_DIV-1. With
    // TICK_DIV == 1 the count stays at 0 and tick is high every cycle.
    logic [PS_W-1:0] ps_cnt;
    logic            tick;

    assign tick = (ps_cnt == PS_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Per-bit qualification counters and debounced state
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            deb_q;
    logic [WIDTH-1:0]            deb_d;
    logic [WIDTH-1:0]            chg_d;

    // Next-state logic. Bits are independent. For each bit:
    //   - A match between s2 and the debounced level clears the counter every
    //     cycle. A bounce back therefore discards all progress, and a match
    //     wins over a tick that lands in the same cycle.
    //   - A mismatch without a tick holds the counter.
    //   - A mismatch on a tick advances the counter. On the STABLE_TICKS-th
    //     such tick the new level is accepted and the counter returns to 0.
    //     The counter therefore never exceeds STABLE_TICKS-1.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        chg_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = s2[i];
                    cnt_d[i] = '0;
                    chg_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // The outputs are registered together, so debounced, changed and
    // any_changed all move on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            deb_q       <= RESET_VALUE;
            changed     <= '0;
            any_changed <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            deb_q       <= deb_d;
            changed     <= chg_d;
            any_changed <= |chg_d;
        end
    end

    assign debounced = deb_q;

endmodule

// File: tb/tb_nios_system_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_nios_system_switch_debouncer
//
// Directed bench for the switch debouncer. The main instance uses
// TICK_DIV=4 and STABLE_TICKS=3, so a held level is accepted 11..14 edges
// after the raw edge. A second instance uses TICK_DIV=1 and STABLE_TICKS=1,
// so acceptance happens exactly 3 edges after the raw edge.
//
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at
// that same point, well away from the active edge. Each scenario task
// compares its own results against hand-derived values.
// -----------------------------------------------------------------------------
module tb_nios_system_switch_debouncer;

    localparam int W = 18;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [W-1:0] raw_sw;
    logic [W-1:0] debounced;
    logic [W-1:0] changed;
    logic         any_changed;

    logic         reset_n_b;
    logic [W-1:0] raw_b;
    logic [W-1:0] debounced_b;
    logic [W-1:0] changed_b;
    logic         any_changed_b;

    nios_system_switch_debouncer #(
        .WIDTH(W), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_VALUE('0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_sw(raw_sw),
        .debounced(debounced), .changed(changed), .any_changed(any_changed)
    );

    nios_system_switch_debouncer #(
        .WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(1), .RESET_VALUE('0)
    ) dut_fast (
        .clk(clk), .reset_n(reset_n_b), .raw_sw(raw_b),
        .debounced(debounced_b), .changed(changed_b), .any_changed(any_changed_b)
    );

    // ---------------- counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    // ---------------- observation state (main instance) ----------------
    int           edge_ctr;
    int           first_edge;
    int           watch_bit;
    logic         watch_start;
    int           pulse_cycles;
    int           watch_pulses;
    int           any_err;
    logic [W-1:0] chg_or;

    // Arms the observer: the first edge is counted from the next rising edge.
    task automatic clear_obs(input int b);
        edge_ctr     = 0;
        first_edge   = -1;
        watch_bit    = b;
        watch_start  = debounced[b];
        pulse_cycles = 0;
        watch_pulses = 0;
        any_err      = 0;
        chg_or       = '0;
    endtask

    // Advances n edges and accumulates what the outputs did.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            edge_ctr++;
            if (first_edge < 0 && debounced[watch_bit] !== watch_start)
                first_edge = edge_ctr;
            if (changed !== '0) pulse_cycles++;
            if (changed[watch_bit] === 1'b1) watch_pulses++;
            chg_or = chg_or | changed;
            if (any_changed !== (|changed)) any_err++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n   = 1'b0;
        reset_n_b = 1'b0;
        raw_sw    = 18'h3FFFF;
        raw_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (debounced !== 18'h0) begin
            n_err++;
            $display("FAIL reset_debounced: got %h want %h", debounced, 18'h0);
        end
        n_cmp++;
        if (changed !== 18'h0) begin
            n_err++;
            $display("FAIL reset_changed: got %h want %h", changed, 18'h0);
        end
        n_cmp++;
        if (any_changed !== 1'b0) begin
            n_err++;
            $display("FAIL reset_any_changed: got %b want 0", any_changed);
        end
        reset_n   = 1'b1;
        reset_n_b = 1'b1;
        clear_obs(0);
        step(20);
        n_cmp++;
        if (first_edge < 11 || first_edge > 14) begin
            n_err++;
            $display("FAIL reset_release_latency: got %0d want 11..14", first_edge);
        end
        n_cmp++;
        if (pulse_cycles != 1) begin
            n_err++;
            $display("FAIL reset_release_pulses: got %0d want 1", pulse_cycles);
        end
        n_cmp++;
        if (chg_or !== 18'h3FFFF) begin
            n_err++;
            $display("FAIL reset_release_changed: got %h want %h", chg_or, 18'h3FFFF);
        end
        n_cmp++;
        if (debounced !== 18'h3FFFF) begin
            n_err++;
            $display("FAIL reset_release_level: got %h want %h", debounced, 18'h3FFFF);
        end
        n_cmp++;
        if (any_err != 0) begin
            n_err++;
            $display("FAIL reset_any_align: got %0d want 0 misaligned cycles", any_err);
        end
    endtask

    task automatic test_all_fall();
        raw_sw = '0;
        clear_obs(0);
        step(20);
        n_cmp++;
        if (debounced !== 18'h0) begin
            n_err++;
            $display("FAIL all_fall_level: got %h want %h", debounced, 18'h0);
        end
        n_cmp++;
        if (pulse_cycles != 1) begin
            n_err++;
            $display("FAIL all_fall_pulses: got %0d want 1", pulse_cycles);
        end
    endtask

    task automatic test_clean_flip();
        raw_sw[5] = 1'b1;
        clear_obs(5);
        step(20);
        n_cmp++;
        if (first_edge < 11 || first_edge > 14) begin
            n_err++;
            $display("FAIL clean_flip_latency: got %0d want 11..14", first_edge);
        end
        n_cmp++;
        if (watch_pulses != 1) begin
            n_err++;
            $display("FAIL clean_flip_pulse_width: got %0d want 1", watch_pulses);
        end
        n_cmp++;
        if (chg_or !== 18'h00020) begin
            n_err++;
            $display("FAIL clean_flip_changed: got %h want %h", chg_or, 18'h00020);
        end
        n_cmp++;
        if (debounced !== 18'h00020) begin
            n_err++;
            $display("FAIL clean_flip_level: got %h want %h", debounced, 18'h00020);
        end
        n_cmp++;
        if (any_err != 0) begin
            n_err++;
            $display("FAIL clean_flip_any_align: got %0d want 0", any_err);
        end
    endtask

    // Six cycles high can hold at most two ticks, so no level is accepted.
    task automatic test_bounce_reject();
        clear_obs(0);
        for (int r = 0; r < 5; r++) begin
            raw_sw[0] = 1'b1;
            step(6);
            raw_sw[0] = 1'b0;
            step(2);
        end
        step(14);
        n_cmp++;
        if (debounced[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_reject_level: got %b want 0", debounced[0]);
        end
        n_cmp++;
        if (chg_or !== 18'h0) begin
            n_err++;
            $display("FAIL bounce_reject_changed: got %h want %h", chg_or, 18'h0);
        end
        n_cmp++;
        if (debounced !== 18'h00020) begin
            n_err++;
            $display("FAIL bounce_reject_others: got %h want %h", debounced, 18'h00020);
        end
    endtask

    task automatic test_bounce_settle();
        clear_obs(17);
        for (int r = 0; r < 5; r++) begin
            raw_sw[17] = 1'b1;
            step(6);
            raw_sw[17] = 1'b0;
            step(2);
        end
        n_cmp++;
        if (chg_or !== 18'h0) begin
            n_err++;
            $display("FAIL bounce_settle_early: got %h want %h", chg_or, 18'h0);
        end
        raw_sw[17] = 1'b1;
        clear_obs(17);
        step(20);
        n_cmp++;
        if (first_edge < 11 || first_edge > 14) begin
            n_err++;
            $display("FAIL bounce_settle_latency: got %0d want 11..14", first_edge);
        end
        n_cmp++;
        if (watch_pulses != 1 || pulse_cycles != 1) begin
            n_err++;
            $display("FAIL bounce_settle_pulses: got %0d/%0d want 1/1", watch_pulses, pulse_cycles);
        end
        n_cmp++;
        if (chg_or !== 18'h20000) begin
            n_err++;
            $display("FAIL bounce_settle_changed: got %h want %h", chg_or, 18'h20000);
        end
        n_cmp++;
        if (debounced !== 18'h20020) begin
            n_err++;
            $display("FAIL bounce_settle_level: got %h want %h", debounced, 18'h20020);
        end
    endtask

    task automatic test_simultaneous();
        raw_sw[3] = 1'b1;
        raw_sw[9] = 1'b1;
        clear_obs(3);
        step(1);
        raw_sw[9] = 1'b0;
        step(19);
        n_cmp++;
        if (first_edge < 11 || first_edge > 14) begin
            n_err++;
            $display("FAIL simultaneous_latency: got %0d want 11..14", first_edge);
        end
        n_cmp++;
        if (chg_or !== 18'h00008) begin
            n_err++;
            $display("FAIL simultaneous_changed: got %h want %h", chg_or, 18'h00008);
        end
        n_cmp++;
        if (pulse_cycles != 1) begin
            n_err++;
            $display("FAIL simultaneous_pulses: got %0d want 1", pulse_cycles);
        end
        n_cmp++;
        if (debounced !== 18'h20028) begin
            n_err++;
            $display("FAIL simultaneous_level: got %h want %h", debounced, 18'h20028);
        end
    endtask

    // Bits 3, 5 and 17 are still high on raw_sw. After release they
    // requalify from zero together with bit 2.
    task automatic test_reset_mid();
        raw_sw[2] = 1'b1;
        clear_obs(2);
        step(6);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (debounced !== 18'h0) begin
            n_err++;
            $display("FAIL reset_mid_level: got %h want %h", debounced, 18'h0);
        end
        n_cmp++;
        if (changed !== 18'h0 || any_changed !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_changed: got %h/%b want 0/0", changed, any_changed);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_obs(2);
        step(20);
        n_cmp++;
        if (first_edge < 11 || first_edge > 14) begin
            n_err++;
            $display("FAIL reset_mid_latency: got %0d want 11..14", first_edge);
        end
        n_cmp++;
        if (watch_pulses != 1 || pulse_cycles != 1) begin
            n_err++;
            $display("FAIL reset_mid_pulses: got %0d/%0d want 1/1", watch_pulses, pulse_cycles);
        end
        n_cmp++;
        if (chg_or !== 18'h2002C) begin
            n_err++;
            $display("FAIL reset_mid_changed_bits: got %h want %h", chg_or, 18'h2002C);
        end
        n_cmp++;
        if (debounced !== 18'h2002C) begin
            n_err++;
            $display("FAIL reset_mid_final: got %h want %h", debounced, 18'h2002C);
        end
    endtask

    // TICK_DIV=1, STABLE_TICKS=1: two synchronizer edges plus one
    // acceptance edge.
    task automatic test_fast();
        int first_b;
        int pulses_b;
        int any_err_b;
        first_b   = -1;
        pulses_b  = 0;
        any_err_b = 0;
        raw_b[4]  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (first_b < 0 && debounced_b[4] === 1'b1) first_b = k;
            if (changed_b[4] === 1'b1) pulses_b++;
            if (any_changed_b !== (|changed_b)) any_err_b++;
        end
        n_cmp++;
        if (first_b != 3) begin
            n_err++;
            $display("FAIL fast_latency: got %0d want 3", first_b);
        end
        n_cmp++;
        if (pulses_b != 1) begin
            n_err++;
            $display("FAIL fast_pulses: got %0d want 1", pulses_b);
        end
        n_cmp++;
        if (debounced_b !== 18'h00010 || any_err_b != 0) begin
            n_err++;
            $display("FAIL fast_level: got %h (align errs %0d) want %h (0)",
                     debounced_b, any_err_b, 18'h00010);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_all_fall();
        test_clean_flip();
        test_bounce_reject();
        test_bounce_settle();
        test_simultaneous();
        test_reset_mid();
        test_fast();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Every wait above is a bounded edge count. This is a backstop only.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
